// File: rtl/bram_delay_prog.sv
// ---------------------------------------------------------------------------
// bram_delay_prog
// Runtime-programmable, clock-enable-gated delay line on an inferred
// simple-dual-port block RAM. The requested delay is clamped to
// LATENCY+1 .. MAX_DELAY; an out-of-range request raises delay_err.
// After a reset or a delay change the line refills, and dout stays at 0
// with dout_valid low until the first sample of the new stream arrives.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset (overrides ce)
//   ce          clock enable; all state advances only when high
//   delay       requested delay in ce-cycles (DBITS wide)
//   din         input sample
//   dout        delayed sample, registered, 0 while refilling
//   dout_valid  dout holds a sample written since the last restart
//   delay_err   registered, high while delay is out of range
//
// state | meaning
// ------+---------------------------------------------------------------
// FILL  | line refilling after reset/delay change; dout forced to 0
// RUN   | dout carries din delayed by the active delay
// ---------------------------------------------------------------------------
module bram_delay_prog #(
    parameter  int WIDTH     = 32,
    parameter  int MAX_DELAY = 1024,
    parameter  int LATENCY   = 2,
    localparam int DBITS     = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [DBITS-1:0] delay,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             delay_err
);

    localparam int AW    = ($clog2(MAX_DELAY) < 9) ? 9 : $clog2(MAX_DELAY);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t           state_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [DBITS-1:0] delay_q;
    logic [DBITS-1:0] fill_cnt_q;
    // Set by reset: the first ce-cycle afterwards is the restart cycle that
    // writes sample 0, exactly like a delay-change cycle.
    logic             restart_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             err_q;

    logic [DBITS-1:0] delay_clamp_d;
    logic             err_d;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] pipe_out;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_pipe_q [LATENCY];

    always_comb begin
        delay_clamp_d = delay;
        err_d         = 1'b0;
        if (delay < DBITS'(LATENCY + 1)) begin
            delay_clamp_d = DBITS'(LATENCY + 1);
            err_d         = 1'b1;
        end else if (delay > DBITS'(MAX_DELAY)) begin
            delay_clamp_d = DBITS'(MAX_DELAY);
            err_d         = 1'b1;
        end
    end

    // Modulo-depth arithmetic; truncating delay_q to AW bits is exact mod DEPTH.
    assign rd_addr  = wr_ptr_q - AW'(delay_q) + AW'(LATENCY);
    assign pipe_out = rd_pipe_q[LATENCY-1];

    // RAM and read pipeline: no reset so they map onto block RAM.
    // rd_addr never equals wr_ptr_q because delay_q >= LATENCY+1.
    always_ff @(posedge clk) begin
        if (ce && !rst) begin
            mem[wr_ptr_q] <= din;
        end
        if (ce) begin
            rd_pipe_q[0] <= mem[rd_addr];
            for (int i = 1; i < LATENCY; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        err_q <= err_d;
        if (rst) begin
            state_q    <= S_FILL;
            wr_ptr_q   <= '0;
            delay_q    <= delay_clamp_d;
            fill_cnt_q <= '0;
            restart_q  <= 1'b1;
            dout_q     <= '0;
            valid_q    <= 1'b0;
        end else if (ce) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (restart_q || (delay_clamp_d != delay_q)) begin
                // This cycle's din is sample 0 of the new stream; anything
                // still in the read pipeline belongs to the old one.
                delay_q    <= delay_clamp_d;
                fill_cnt_q <= '0;
                restart_q  <= 1'b0;
                state_q    <= S_FILL;
                dout_q     <= '0;
                valid_q    <= 1'b0;
            end else if (state_q == S_FILL) begin
                if (fill_cnt_q != delay_q) begin
                    fill_cnt_q <= fill_cnt_q + 1'b1;
                end
                // pipe_out now holds sample 0, read under the new delay.
                if (fill_cnt_q == delay_q - DBITS'(1)) begin
                    state_q <= S_RUN;
                    dout_q  <= pipe_out;
                    valid_q <= 1'b1;
                end else begin
                    dout_q  <= '0;
                end
            end else begin
                dout_q <= pipe_out;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign delay_err  = err_q;

endmodule

// File: tb/tb_bram_delay_prog.sv
// Scoreboard bench for bram_delay_prog (WIDTH=32, MAX_DELAY=1024, LATENCY=2).
// The reference keeps the samples of the current stream in a queue and
// predicts dout/dout_valid/delay_err for every clock edge.
module tb_bram_delay_prog;

    localparam int WIDTH     = 32;
    localparam int MAX_DELAY = 1024;
    localparam int LATENCY   = 2;
    localparam int DBITS     = $clog2(MAX_DELAY + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic [DBITS-1:0] delay;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             delay_err;

    bram_delay_prog #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .ce(ce), .delay(delay), .din(din),
        .dout(dout), .dout_valid(dout_valid), .delay_err(delay_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             v;
        logic             e;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] hist[$];
    int               m_d;
    int               m_dc;
    bit               m_pend;
    bit               started;
    logic [WIDTH-1:0] e_dout;
    logic             e_valid;
    int               n_cmp;
    int               n_err;
    int               n_valid_seen;
    int               n_print;

    function automatic int clampd(input int d);
        if (d < LATENCY + 1) return LATENCY + 1;
        if (d > MAX_DELAY) return MAX_DELAY;
        return d;
    endfunction

    // Reference model: inputs are stable around posedge (driven #1 after it).
    always @(posedge clk) begin
        m_dc = clampd(int'(delay));
        if (rst) begin
            hist.delete();
            m_d     = m_dc;
            m_pend  = 1'b1;
            e_dout  = '0;
            e_valid = 1'b0;
            started = 1'b1;
        end else if (started && ce) begin
            if (m_pend || m_dc != m_d) begin
                hist.delete();
                hist.push_back(din);
                m_d     = m_dc;
                m_pend  = 1'b0;
                e_dout  = '0;
                e_valid = 1'b0;
            end else begin
                hist.push_back(din);
                if (hist.size() > m_d + 1) void'(hist.pop_front());
                if (hist.size() == m_d + 1) begin
                    e_dout  = hist[0];
                    e_valid = 1'b1;
                end else begin
                    e_dout  = '0;
                    e_valid = 1'b0;
                end
            end
        end
        if (started)
            exp_q.push_back('{d: e_dout, v: e_valid,
                              e: (int'(delay) < LATENCY + 1) || (int'(delay) > MAX_DELAY)});
    end

    task automatic note_fail(input string what, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_err++;
        if (n_print < 30) begin
            n_print++;
            $display("FAIL %s at %0t: got %h expected %h", what, $time, act, req);
        end
    endtask

    // Monitor: one expected entry per clock edge, checked on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp += 3;
            if (dout !== e.d)             note_fail("dout", dout, e.d);
            if (dout_valid !== e.v)       note_fail("dout_valid", WIDTH'(dout_valid), WIDTH'(e.v));
            if (delay_err !== e.e)        note_fail("delay_err", WIDTH'(delay_err), WIDTH'(e.e));
            if (e.v) n_valid_seen++;
        end
    end

    task automatic step(input logic r, input logic c, input int d, input logic [WIDTH-1:0] x);
        rst   = r;
        ce    = c;
        delay = DBITS'(d);
        din   = x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] ramp;
        n_cmp = 0; n_err = 0; n_valid_seen = 0; n_print = 0;
        started = 1'b0; m_pend = 1'b0; m_d = 0;
        e_dout = '0; e_valid = 1'b0;
        rst = 1'b1; ce = 1'b0; delay = DBITS'(10); din = '0;

        // Reset, then ramp at delay 10 with ce held high.
        step(1, 0, 10, 0);
        step(1, 1, 10, 32'hdead_beef);
        ramp = 1;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 10, ramp);
            ramp++;
        end

        // ce toggled pseudo-randomly at delay 10.
        for (int i = 0; i < 5000; i++) step(0, 1'($urandom_range(0, 1)), 10, $urandom);

        // Maximum delay across several pointer wraps.
        for (int i = 0; i < 3000; i++) step(0, 1, MAX_DELAY, $urandom);

        // Change 10 -> 20 while running.
        for (int i = 0; i < 40; i++) step(0, 1, 10, $urandom);
        for (int i = 0; i < 60; i++) step(0, 1, 20, $urandom);

        // Out-of-range low and high, then back in range.
        for (int i = 0; i < 30; i++)   step(0, 1, 0, $urandom);
        for (int i = 0; i < 1100; i++) step(0, 1, 2000, $urandom);
        for (int i = 0; i < 40; i++)   step(0, 1, 10, $urandom);

        // One-cycle reset mid-RUN; stale RAM must not show on dout.
        step(1, 1, 10, $urandom);
        for (int i = 0; i < 40; i++) step(0, 1, 10, $urandom);

        // Random delay segments, random ce, occasional resets and
        // delay wiggles during ce=0 (must not restart).
        for (int s = 0; s < 40; s++) begin
            int d;
            int len;
            d   = (s % 4 == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 60));
            len = int'($urandom_range(1, 250));
            for (int i = 0; i < len; i++) begin
                logic c;
                c = 1'($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 999) == 0)
                    step(1, c, d, $urandom);
                else if (!c && $urandom_range(0, 3) == 0)
                    step(0, 0, int'($urandom_range(0, 60)), $urandom);
                else
                    step(0, c, d, $urandom);
            end
        end

        step(0, 0, 10, 0);
        step(0, 0, 10, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) note_fail("scoreboard_drain", WIDTH'(exp_q.size()), '0);
        n_cmp++;
        if (n_valid_seen < 1000) note_fail("valid_coverage", WIDTH'(n_valid_seen), WIDTH'(1000));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
